phase_wrap_gen: RTL and testbench

PHASE_WRAP_GEN -- requirements
Module: phase_wrap_gen

---
 rtl/phase_wrap_gen_if.sv | 27 ++
 rtl/phase_wrap_gen.sv | 172 +++++++++++++++++
 tb/tb_phase_wrap_gen.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_wrap_gen_if.sv
// Command/stream bundle for the phase wrap generator: sequence request in,
// wrapped angle stream out, plus status flags.
interface phase_wrap_gen_if #(
  parameter int TOTAL_WIDTH = 16
);
  logic                          start;
  logic signed [TOTAL_WIDTH-1:0] phase0;
  logic signed [TOTAL_WIDTH-1:0] step;
  logic [7:0]                    count;
  logic signed [TOTAL_WIDTH-1:0] x_out;
  logic [7:0]                    idx_out;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;
  logic                          done;
  logic                          step_clip;

  modport master (
    output start, phase0, step, count, out_ready,
    input  x_out, idx_out, out_valid, busy, done, step_clip
  );

  modport slave (
    input  start, phase0, step, count, out_ready,
    output x_out, idx_out, out_valid, busy, done, step_clip
  );
endinterface

// File: rtl/phase_wrap_gen.sv
// Generates a sequence of angles phase0 + k*step wrapped into [-pi, pi),
// streamed one per handshake to a sine approximator.
module phase_wrap_gen #(
  parameter int TOTAL_WIDTH = 16,
  parameter int FRAC_WIDTH  = 5,
  parameter int PI_FX       = 101
) (
  input logic             clk,
  input logic             rst,
  phase_wrap_gen_if.slave bus
);

  localparam int W = TOTAL_WIDTH;
  localparam logic signed [W-1:0] PI_W     = W'(PI_FX);
  localparam logic signed [W:0]   PI_E     = (W+1)'(PI_FX);
  localparam logic signed [W:0]   TWO_PI_E = (W+1)'(2 * PI_FX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  if (FRAC_WIDTH >= TOTAL_WIDTH) begin : g_bad_frac
    $error("phase_wrap_gen: FRAC_WIDTH must be smaller than TOTAL_WIDTH");
  end

  // Single-correction wrap; valid because inputs lie in [-2*pi, 2*pi).
  function automatic logic signed [W-1:0] wrap_fx(input logic signed [W:0] v);
    logic signed [W:0] r;
    if (v >= PI_E) begin
      r = v - TWO_PI_E;
    end else if (v < -PI_E) begin
      r = v + TWO_PI_E;
    end else begin
      r = v;
    end
    return r[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_fx(input logic signed [W-1:0] v);
    logic signed [W-1:0] r;
    if (v > PI_W) begin
      r = PI_W;
    end else if (v < -PI_W) begin
      r = -PI_W;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic signed [W-1:0] x_r;
  logic signed [W-1:0] step_r;
  logic [7:0]          idx_r;
  logic [7:0]          count_r;
  logic                clip_r;
  logic                valid_s;
  logic                busy_s;
  logic                done_s;
  logic                accept_s;
  logic                hs_s;
  logic                last_s;
  logic                clip_s;
  logic signed [W:0]   sum_s;
  logic signed [W:0]   phase_ext_s;

  assign accept_s    = (state_r == IDLE) && bus.start;
  assign hs_s        = (state_r == RUN) && bus.out_ready;
  assign last_s      = (idx_r == (count_r - 8'd1));
  assign clip_s      = (bus.step > PI_W) || (bus.step < -PI_W);
  assign sum_s       = $signed({x_r[W-1], x_r}) + $signed({step_r[W-1], step_r});
  assign phase_ext_s = $signed({bus.phase0[W-1], bus.phase0});

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx_s = (bus.count == 8'd0) ? DONE : RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (hs_s && last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Status decode straight from the state register, so no combinational input paths
  always_comb begin
    valid_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
      RUN: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        done_s  = 1'b0;
      end
      DONE: begin
        valid_s = 1'b0;
        busy_s  = 1'b1;
        done_s  = 1'b1;
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Angle datapath; holds everything while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r     <= {W{1'b0}};
      step_r  <= {W{1'b0}};
      idx_r   <= 8'd0;
      count_r <= 8'd0;
    end else if (accept_s) begin
      x_r     <= wrap_fx(phase_ext_s);
      step_r  <= sat_fx(bus.step);
      idx_r   <= 8'd0;
      count_r <= bus.count;
    end else if (hs_s && !last_s) begin
      x_r     <= wrap_fx(sum_s);
      idx_r   <= idx_r + 8'd1;
    end
  end

  // Sticky saturation flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_r <= 1'b0;
    end else if (accept_s && clip_s) begin
      clip_r <= 1'b1;
    end
  end

  assign bus.x_out     = x_r;
  assign bus.idx_out   = idx_r;
  assign bus.out_valid = valid_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;
  assign bus.step_clip = clip_r;

endmodule

// File: tb/tb_phase_wrap_gen.sv
// Self-checking bench for phase_wrap_gen: table vectors, hand-written corner
// sequences and randomized runs against a closed-form modular-angle model.
module tb_phase_wrap_gen;

  localparam int PI     = 101;
  localparam int TWO_PI = 202;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   clip_exp;
  int   got_q[$];

  phase_wrap_gen_if #(.TOTAL_WIDTH(16)) bus ();

  phase_wrap_gen #(
    .TOTAL_WIDTH(16),
    .FRAC_WIDTH (5),
    .PI_FX      (101)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int phase0;
    int step;
    int count;
    int clip;
    int nexp;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int sat(input int s);
    if (s > PI) return PI;
    if (s < -PI) return -PI;
    return s;
  endfunction

  // Sample k of the sequence is the angle phase0 + k*step reduced modulo 2*pi into [-pi, pi)
  function automatic int model_x(input int p0, input int st, input int k);
    int v;
    v = (p0 + k * sat(st) + PI) % TWO_PI;
    if (v < 0) v = v + TWO_PI;
    return v - PI;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_x", bus.x_out, 0);
    chk("rst_idx", bus.idx_out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_clip", bus.step_clip, 0);
    rst = 1'b0;
    clip_exp = 0;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on sample 1
  task automatic run_seq(input int p0, input int st, input int cnt, input int mode);
    int  hs_n;
    int  last_hs;
    int  done_c;
    int  stall;
    int  prev_x;
    int  prev_idx;
    bit  prev_stall;
    bit  r;
    got_q.delete();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.phase0    = 16'(p0);
    bus.step      = 16'(st);
    bus.count     = 8'(cnt);
    bus.out_ready = 1'b1;
    if (st > PI || st < -PI) clip_exp = 1;
    hs_n = 0; last_hs = 0; done_c = -1; stall = 0; prev_stall = 1'b0;
    prev_x = 0; prev_idx = 0;
    for (int c = 1; c < 600 && done_c < 0; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_x", bus.x_out, prev_x);
        chk("hold_idx", bus.idx_out, prev_idx);
      end
      chk("valid_done_excl", int'(bus.out_valid & bus.done), 0);
      if (bus.done) begin
        done_c = c;
        chk("done_timing", c, last_hs + 1);
        chk("hs_count", hs_n, cnt);
        chk("busy_in_done", bus.busy, 1);
      end
      case (mode)
        1: r = 1'($urandom_range(0, 1));
        2: begin
          if (bus.out_valid && bus.idx_out == 8'd1 && stall < 3) begin
            r = 1'b0;
            stall++;
          end else begin
            r = 1'b1;
          end
        end
        default: r = 1'b1;
      endcase
      bus.out_ready = r;
      // start while busy (including the done cycle) must be ignored
      bus.start  = (bus.done || $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      bus.phase0 = 16'(int'($urandom_range(0, 200)) - 100);
      bus.step   = 16'(int'($urandom_range(0, 200)) - 100);
      bus.count  = 8'($urandom_range(1, 255));
      if (bus.out_valid) begin
        chk("x_out", bus.x_out, model_x(p0, st, hs_n));
        chk("idx_out", bus.idx_out, hs_n);
        if (r) begin
          got_q.push_back(int'(bus.x_out));
          hs_n++;
          last_hs = c;
        end
      end
      prev_stall = bus.out_valid && !r;
      prev_x     = bus.x_out;
      prev_idx   = bus.idx_out;
    end
    if (done_c < 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_valid", bus.out_valid, 0);
    chk("clip_flag", bus.step_clip, clip_exp);
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  vec_t vecs[5];
  int   exp_x[5][10];

  initial begin
    int  seen;
    int  p0;
    int  st;
    int  cn;
    n_pass = 0;
    n_total = 0;
    clip_exp = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.phase0 = 16'sd0;
    bus.step = 16'sd0;
    bus.count = 8'd0;
    bus.out_ready = 1'b1;

    vecs[0] = '{phase0: 0,    step: 25,   count: 10, clip: 0, nexp: 10};
    vecs[1] = '{phase0: -90,  step: -40,  count: 3,  clip: 0, nexp: 3};
    vecs[2] = '{phase0: 0,    step: 300,  count: 3,  clip: 1, nexp: 3};
    vecs[3] = '{phase0: 190,  step: -101, count: 4,  clip: 0, nexp: 4};
    vecs[4] = '{phase0: -202, step: -300, count: 2,  clip: 1, nexp: 2};
    exp_x = '{'{0, 25, 50, 75, 100, -77, -52, -27, -2, 23},
              '{-90, 72, 32, 0, 0, 0, 0, 0, 0, 0},
              '{0, -101, 0, 0, 0, 0, 0, 0, 0, 0},
              '{-12, 89, -12, 89, 0, 0, 0, 0, 0, 0},
              '{0, -101, 0, 0, 0, 0, 0, 0, 0, 0}};

    do_reset();

    for (int v = 0; v < 5; v++) begin
      do_reset();
      run_seq(vecs[v].phase0, vecs[v].step, vecs[v].count, 0);
      chk("tab_len", got_q.size(), vecs[v].nexp);
      for (int i = 0; i < vecs[v].nexp && i < got_q.size(); i++) begin
        chk("tab_x", got_q[i], exp_x[v][i]);
      end
      chk("tab_clip", bus.step_clip, vecs[v].clip);
    end

    // Stall on sample 1, then resume unchanged
    do_reset();
    run_seq(0, 25, 4, 2);
    chk("stall_len", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("stall_x1", got_q[1], 25);
      chk("stall_x2", got_q[2], 50);
      chk("stall_x3", got_q[3], 75);
    end

    // Zero-length sequence
    run_seq(5, 10, 0, 0);
    chk("zero_len", got_q.size(), 0);

    // Reset in the middle of a run, asserted together with start
    do_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.phase0 = 16'sd0; bus.step = 16'sd25; bus.count = 8'd10;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.out_valid && bus.idx_out == 8'd3) seen = 1;
    end
    chk("mid_reached_idx3", seen, 1);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("mid_rst_x", bus.x_out, 0);
    chk("mid_rst_idx", bus.idx_out, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    clip_exp = 0;
    @(negedge clk);
    chk("mid_post_done", bus.done, 0);
    chk("mid_post_busy", bus.busy, 0);
    run_seq(0, 25, 10, 0);
    chk("mid_rerun_len", got_q.size(), 10);

    // Randomized runs with random back-pressure
    for (int n = 0; n < 30; n++) begin
      if (n % 10 == 0) do_reset();
      p0 = int'($urandom_range(0, 403)) - 202;
      st = int'($urandom_range(0, 800)) - 400;
      cn = int'($urandom_range(0, 20));
      run_seq(p0, st, cn, 1);
      chk("rand_len", got_q.size(), cn);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
